// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register for femtorv32: captures execute results with stall/flush,
// resolves conditional branches from registered flags and drives forwarding/redirect.
module ex_mem_reg #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [XLEN-1:0] ex_branch_target,
  input  logic [4:0]      ex_rd,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_zf,
  input  logic            ex_cf,
  input  logic            ex_vf,
  input  logic            ex_sf,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic [1:0]      ex_wb_sel,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_rs2_data,
  output logic [XLEN-1:0] mem_branch_target,
  output logic [4:0]      mem_rd,
  output logic [2:0]      mem_funct3,
  output logic [1:0]      mem_wb_sel,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic            mem_pc_src,
  output logic [4:0]      fwd_rd,
  output logic            fwd_en
);

  localparam int unsigned RD_W = 5;
  localparam int unsigned F3_W = 3;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] branch_target;
    logic [RD_W-1:0] rd;
    logic [F3_W-1:0] funct3;
    logic [1:0]      wb_sel;
    logic            zf;
    logic            cf;
    logic            vf;
    logic            sf;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
  } stage_t;

  stage_t ex_s;
  stage_t stage_d;
  stage_t stage_q;
  logic   taken;

  // Incoming stage payload; control bits gated so an invalid slot becomes a bubble
  always_comb begin
    ex_s               = '0;
    ex_s.valid         = ex_valid;
    ex_s.alu_result    = ex_alu_result;
    ex_s.rs2_data      = ex_rs2_data;
    ex_s.branch_target = ex_branch_target;
    ex_s.rd            = ex_rd;
    ex_s.funct3        = ex_funct3;
    ex_s.wb_sel        = ex_wb_sel;
    ex_s.zf            = ex_zf;
    ex_s.cf            = ex_cf;
    ex_s.vf            = ex_vf;
    ex_s.sf            = ex_sf;
    ex_s.reg_write     = ex_valid & ex_reg_write;
    ex_s.mem_read      = ex_valid & ex_mem_read;
    ex_s.mem_write     = ex_valid & ex_mem_write;
    ex_s.branch        = ex_valid & ex_branch;
    ex_s.jump          = ex_valid & ex_jump;
  end

  // Next-state: flush beats stall; data fields still load during a flush
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d           = ex_s;
      stage_d.valid     = 1'b0;
      stage_d.reg_write = 1'b0;
      stage_d.mem_read  = 1'b0;
      stage_d.mem_write = 1'b0;
      stage_d.branch    = 1'b0;
      stage_d.jump      = 1'b0;
    end else if (!stall) begin
      stage_d = ex_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Branch condition from registered flags of a - b
  always_comb begin
    taken = 1'b0;
    case (stage_q.funct3)
      3'b000:  taken = stage_q.zf;
      3'b001:  taken = ~stage_q.zf;
      3'b100:  taken = stage_q.sf ^ stage_q.vf;
      3'b101:  taken = ~(stage_q.sf ^ stage_q.vf);
      3'b110:  taken = ~stage_q.cf;
      3'b111:  taken = stage_q.cf;
      default: taken = 1'b0;
    endcase
  end

  assign mem_valid         = stage_q.valid;
  assign mem_alu_result    = stage_q.alu_result;
  assign mem_rs2_data      = stage_q.rs2_data;
  assign mem_branch_target = stage_q.branch_target;
  assign mem_rd            = stage_q.rd;
  assign mem_funct3        = stage_q.funct3;
  assign mem_wb_sel        = stage_q.wb_sel;
  assign mem_reg_write     = stage_q.reg_write;
  assign mem_mem_read      = stage_q.mem_read;
  assign mem_mem_write     = stage_q.mem_write;

  assign mem_pc_src = stage_q.valid & ((stage_q.branch & taken) | stage_q.jump);

  // Loads are not forwarded from here; x0 writes never forward
  assign fwd_en = stage_q.valid & stage_q.reg_write & (stage_q.rd != RD_W'(0)) & ~stage_q.mem_read;
  assign fwd_rd = fwd_en ? stage_q.rd : RD_W'(0);

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

Pipeline register between the execute stage (ALU and shifter) and the memory stage of the femtorv32 core. It captures the ALU result, the store data, the destination register and the control bits every cycle. It supports stall (hold) and flush (bubble insertion). From the registered flags it resolves conditional branches for the memory stage and drives the forwarding and PC-select outputs.

## Interface
Parameters
- XLEN, 32, datapath width.

Ports
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  holds all registers unchanged.
- flush  in  1  loads a bubble (valid=0, all control bits 0).
- ex_valid  in  1  execute stage holds a real instruction.
- ex_alu_result  in  XLEN  ALU/shifter result.
- ex_rs2_data  in  XLEN  store data.
- ex_branch_target  in  XLEN  PC + immediate.
- ex_rd  in  5  destination register.
- ex_funct3  in  3  instruction funct3.
- ex_zf, ex_cf, ex_vf, ex_sf  in  1 each  ALU flags for a - b. cf=1 means no borrow (a >= b unsigned).
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump  in  1 each  control bits.
- ex_wb_sel  in  2  writeback select: 00 alu, 01 mem, 10 pc+4.
- mem_valid  out  1  registered valid.
- mem_alu_result, mem_rs2_data, mem_branch_target  out  XLEN  registered copies.
- mem_rd  out  5; mem_funct3  out  3; mem_wb_sel  out  2  registered copies.
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered control bits, gated by valid.
- mem_pc_src  out  1  combinational redirect request (branch taken or jump).
- fwd_rd  out  5  forwarding destination (mem_rd when forwarding is possible, else 0).
- fwd_en  out  1  forwarding possible.

## Operation
- Each register update follows this priority: rst, then flush, then stall, then load.
- rst (asynchronous): every register is cleared to 0, so every output above reads 0.
- flush: mem_valid and all control bits are set to 0. Data fields may hold any value; verification does not check them.
- stall without flush: every register keeps its value.
- Load: every field takes its ex_ input. Control bits are ANDed with ex_valid, so an invalid input produces a bubble.
- Branch resolution uses the registered flags and mem_funct3:
  - 000 BEQ: zf
  - 001 BNE: !zf
  - 100 BLT: sf ^ vf
  - 101 BGE: !(sf ^ vf)
  - 110 BLTU: !cf
  - 111 BGEU: cf
  - 010 and 011: not taken.
- mem_pc_src = mem_valid & ((mem_branch & taken) | mem_jump).
- fwd_en = mem_valid & mem_reg_write & (mem_rd != 0) & !mem_mem_read. A load result is not forwarded from this stage; the hazard unit stalls for it.
- fwd_rd = fwd_en ? mem_rd : 0.
- mem_rd == 0 with reg_write=1 is legal. The write is architecturally discarded and fwd_en is 0.

## Timing
- Latency is 1 cycle from ex_ inputs at edge N to mem_ outputs after edge N.
- mem_pc_src, fwd_en and fwd_rd are combinational from registers. They have no path from any ex_ input.
- stall and flush asserted together: flush wins and a bubble is loaded.
- rst asserted mid-operation clears state immediately, without waiting for a clock edge. Releasing rst takes effect at the next edge.
- A taken redirect (mem_pc_src=1) is expected to cause the hazard unit to flush ID/EX and EX/MEM on the same edge. This block does not self-flush.

## Test plan
- Reset: load ex_alu_result=32'hDEADBEEF with reg_write=1, then assert rst between edges -> all outputs read 0 immediately, before the next edge.
- Load/stall: cycle 1 load alu_result=32'h00000010, rd=5. Cycle 2 stall=1 with alu_result=32'h00000020 -> outputs stay 0x10, rd=5. Cycle 3 stall=0 -> outputs 0x20.
- Flush priority: stall=1 and flush=1 with valid input -> mem_valid=0, mem_reg_write=0, mem_mem_write=0.
- Branch decode with valid=1 and branch=1:
  - funct3=000, zf=1 -> mem_pc_src=1.
  - funct3=100, sf=1, vf=1 -> 0.
  - funct3=110, cf=0 -> 1.
  - funct3=111, cf=0 -> 0.
  - funct3=010 -> 0.
  - jump=1 with branch=0 -> 1.
- Forwarding gating:
  - rd=7, reg_write=1 -> fwd_en=1, fwd_rd=7.
  - Same with mem_read=1 -> fwd_en=0.
  - rd=0 -> fwd_en=0.
- Invalid input: ex_valid=0 with reg_write=1 and mem_write=1 -> mem_valid=0 and all control outputs 0 after the edge.
